// File: rtl/display_state.sv
// Playback engine for the memory-sequence game: replays the latched colour
// sequence (entries 0..round_ctr) with fixed on/gap timing, then pulses completion.
module display_state #(
    parameter int ON_CYCLES  = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_display,
    input  logic        en_display,
    input  logic [31:0] seq_in_display,
    input  logic [3:0]  round_ctr,
    output logic [1:0]  colour_bus,
    output logic        colour_oe,
    output logic        complete_display
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] ON_LAST  = 8'(ON_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_idx;
    logic [31:0] r_seq;
    logic [3:0]  r_round;
    logic [1:0]  r_colour_bus;
    logic        r_colour_oe;
    logic        r_complete;

    state_t      w_state_next;
    logic [7:0]  w_cnt_next;
    logic [3:0]  w_idx_next;
    logic        w_load;
    logic [31:0] w_seq_src;
    logic [1:0]  w_colours [16];

    // On the start edge the colour comes straight from the input so the first
    // colour is visible in the very next cycle.
    assign w_seq_src = w_load ? seq_in_display : r_seq;

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_colour
            assign w_colours[gi] = w_seq_src[2*gi+1:2*gi];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_idx_next   = r_idx;
        w_load       = 1'b0;
        case (r_state)
            IDLE: begin
                if (en_display) begin
                    w_state_next = SHOW;
                    w_cnt_next   = 8'd0;
                    w_idx_next   = 4'd0;
                    w_load       = 1'b1;
                end
            end
            SHOW: begin
                if (r_cnt == ON_LAST) begin
                    w_state_next = GAP;
                    w_cnt_next   = 8'd0;
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cnt_next = 8'd0;
                    if (r_idx == r_round) begin
                        w_state_next = DONE;
                    end else begin
                        w_state_next = SHOW;
                        w_idx_next   = r_idx + 4'd1;
                    end
                end else begin
                    w_cnt_next = r_cnt + 8'd1;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst_display) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_idx        <= 4'd0;
            r_seq        <= 32'd0;
            r_round      <= 4'd0;
            r_colour_bus <= 2'd0;
            r_colour_oe  <= 1'b0;
            r_complete   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            if (w_load) begin
                r_seq   <= seq_in_display;
                r_round <= round_ctr;
            end
            r_colour_oe  <= (w_state_next == SHOW);
            r_colour_bus <= (w_state_next == SHOW) ? w_colours[w_idx_next] : 2'd0;
            r_complete   <= (w_state_next == DONE);
        end
    end

    assign colour_bus       = r_colour_bus;
    assign colour_oe        = r_colour_oe;
    assign complete_display = r_complete;

endmodule

// File: tb/tb_display_state.sv
// Directed bench for display_state: table of playback lengths with hand-computed
// completion cycles, plus held-enable and mid-playback reset sequences.
module tb_display_state;

    localparam int ON  = 4;
    localparam int GAP = 4;

    logic        clk;
    logic        rst_display;
    logic        en_display;
    logic [31:0] seq_in_display;
    logic [3:0]  round_ctr;
    logic [1:0]  colour_bus;
    logic        colour_oe;
    logic        complete_display;

    int n_checks;
    int n_pass;

    display_state #(.ON_CYCLES(ON), .GAP_CYCLES(GAP)) dut (
        .clk              (clk),
        .rst_display      (rst_display),
        .en_display       (en_display),
        .seq_in_display   (seq_in_display),
        .round_ctr        (round_ctr),
        .colour_bus       (colour_bus),
        .colour_oe        (colour_oe),
        .complete_display (complete_display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rc;
        int         exp_done;   // cycle after start where complete_display is high
        int         pulse_at;   // cycle at which to pulse en_display (0 = none)
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Drives one start and checks every cycle of the playback against the
    // timing formula. Inputs are scrambled right after the start to prove they
    // were snapshotted. Called at a negedge; returns at a negedge.
    task automatic run_playback(input logic [3:0] rc, input int exp_done,
                                input int pulse_at, input string tag);
        int n;
        int total;
        int done_seen;
        int oe_windows;
        logic prev_oe;
        int exp_oe, exp_bus, exp_cmp;
        int cyc_errs;
        n = int'(rc) + 1;
        total = n * (ON + GAP) + 4;
        done_seen = 0;
        oe_windows = 0;
        prev_oe = 1'b0;
        cyc_errs = 0;
        round_ctr = rc;
        seq_in_display = 32'hE4E4_E4E4;
        en_display = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en_display = 1'b0;
        seq_in_display = 32'h0000_0000;
        round_ctr = 4'd0;
        for (int j = 1; j <= total; j++) begin
            int t;
            t = j - 1;
            if (t / (ON + GAP) < n) begin
                exp_oe  = ((t % (ON + GAP)) < ON) ? 1 : 0;
                exp_bus = exp_oe ? ((t / (ON + GAP)) % 4) : 0;
                exp_cmp = 0;
            end else begin
                exp_oe  = 0;
                exp_bus = 0;
                exp_cmp = (j == n * (ON + GAP) + 1) ? 1 : 0;
            end
            if (colour_oe !== exp_oe[0] || colour_bus !== exp_bus[1:0]
                || complete_display !== exp_cmp[0]) begin
                cyc_errs++;
                if (cyc_errs <= 4)
                    $display("FAIL %s cycle %0d: oe=%0b bus=%0d cmp=%0b, expected oe=%0d bus=%0d cmp=%0d",
                             tag, j, colour_oe, colour_bus, complete_display,
                             exp_oe, exp_bus, exp_cmp);
            end
            if (complete_display === 1'b1 && done_seen == 0) done_seen = j;
            if (colour_oe === 1'b1 && prev_oe == 1'b0) oe_windows++;
            prev_oe = colour_oe;
            if (pulse_at != 0 && j == pulse_at) en_display = 1'b1;
            else en_display = 1'b0;
            @(negedge clk);
        end
        en_display = 1'b0;
        n_checks++;
        if (cyc_errs == 0) n_pass++;
        check({tag, " done_cycle"}, done_seen, exp_done);
        check({tag, " oe_windows"}, oe_windows, n);
        $display("playback %s round_ctr=%0d done_cycle=%0d windows=%0d cycle_errs=%0d",
                 tag, rc, done_seen, oe_windows, cyc_errs);
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_display = 1'b1;
        en_display = 1'b0;
        seq_in_display = 32'hE4E4_E4E4;
        round_ctr = 4'd0;

        vecs[0] = '{rc: 4'd0,  exp_done: 9,   pulse_at: 0};
        vecs[1] = '{rc: 4'd1,  exp_done: 17,  pulse_at: 0};
        vecs[2] = '{rc: 4'd3,  exp_done: 33,  pulse_at: 0};
        vecs[3] = '{rc: 4'd7,  exp_done: 65,  pulse_at: 0};
        vecs[4] = '{rc: 4'd15, exp_done: 129, pulse_at: 20};

        // Reset with en_display high: reset must win.
        en_display = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset oe", int'(colour_oe), 0);
        check("reset bus", int'(colour_bus), 0);
        check("reset complete", int'(complete_display), 0);
        en_display = 1'b0;
        rst_display = 1'b0;
        repeat (2) @(negedge clk);
        check("idle oe", int'(colour_oe), 0);
        $display("reset outputs oe=%0b bus=%0d cmp=%0b", colour_oe, colour_bus, complete_display);

        for (int v = 0; v < 5; v++) begin
            run_playback(vecs[v].rc, vecs[v].exp_done, vecs[v].pulse_at,
                         $sformatf("vec%0d", v));
            repeat (2) @(negedge clk);
        end

        // en_display held high: restart accepted the cycle after DONE.
        begin
            int oe_hist [14];
            round_ctr = 4'd0;
            seq_in_display = 32'hE4E4_E4E4;
            en_display = 1'b1;
            @(posedge clk);
            for (int j = 1; j <= 13; j++) begin
                @(negedge clk);
                oe_hist[j] = int'(colour_oe);
                if (j == 9) check("held_en complete", int'(complete_display), 1);
            end
            en_display = 1'b0;
            check("held_en idle gap", oe_hist[10], 0);
            check("held_en restart", oe_hist[11], 1);
            $display("held_en oe@10=%0d oe@11=%0d", oe_hist[10], oe_hist[11]);
            repeat (12) @(negedge clk);
            check("held_en drained", int'(colour_oe), 0);
        end

        // Reset mid-SHOW of colour 1 aborts playback silently.
        begin
            int stray;
            round_ctr = 4'd3;
            en_display = 1'b1;
            @(posedge clk);
            @(negedge clk);
            en_display = 1'b0;
            repeat (9) @(negedge clk);
            check("pre_reset oe", int'(colour_oe), 1);
            check("pre_reset bus", int'(colour_bus), 1);
            rst_display = 1'b1;
            @(negedge clk);
            rst_display = 1'b0;
            check("abort oe", int'(colour_oe), 0);
            check("abort bus", int'(colour_bus), 0);
            check("abort complete", int'(complete_display), 0);
            stray = 0;
            for (int j = 0; j < 40; j++) begin
                @(negedge clk);
                if (colour_oe !== 1'b0 || complete_display !== 1'b0) stray++;
            end
            check("abort quiet", stray, 0);
            $display("abort stray_activity=%0d", stray);
        end

        run_playback(4'd1, 17, 0, "after_abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
